// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor: RISC-V branch funct3 encodings
// and the reset value of the direction counters (weakly not-taken).
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // 2^(cnt_bits-1)-1: the highest value whose MSB is still 0.
  function automatic logic [31:0] cnt_reset_val(input int unsigned cnt_bits);
    return (32'd1 << (cnt_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: maps funct3 plus ALU comparator
// flags to the actual branch direction; funct3 010/011 is flagged illegal.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       eq_i,
  input  logic       less_i,
  input  logic       less_u_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BEQ:     taken_o = eq_i;
      BNE:     taken_o = !eq_i;
      BLT:     taken_o = less_i;
      BGE:     taken_o = !less_i;
      BLTU:    taken_o = less_u_i;
      BGEU:    taken_o = !less_u_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: table of saturating counters indexed by PC bits.
// Optional resolve statistics are enabled by defining BRANCH_PRED_STATS_EN.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_req,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic [2:0]      res_funct3,
  input  logic            res_eq,
  input  logic            res_less,
  input  logic            res_less_u,
  input  logic            res_pred_taken,
  output logic            res_done,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic            res_illegal
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int                   TBL_DEPTH = 2 ** IDX_BITS;
  localparam logic [CNT_BITS-1:0]  CNT_RST   = CNT_BITS'(cnt_reset_val(CNT_BITS));
  localparam logic [CNT_BITS-1:0]  CNT_MAX   = {CNT_BITS{1'b1}};

  // Both ports are valid-only with no ready: a request sampled at a rising edge
  // is always consumed, and its result is presented for exactly the next cycle.

  logic [CNT_BITS-1:0] cnt_q [TBL_DEPTH];
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic [CNT_BITS-1:0] cnt_cur;
  logic [CNT_BITS-1:0] cnt_d;
  logic                cond_taken;
  logic                cond_illegal;
  logic                res_mis;
  logic                res_legal;

  logic pred_valid_q, pred_taken_q;
  logic res_done_q, res_taken_q, res_mispredict_q, res_illegal_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_BITS+2], pred_pc[1:0],
                            res_pc[XLEN-1:IDX_BITS+2], res_pc[1:0]};

  assign pred_idx = pred_pc[IDX_BITS+1:2];
  assign res_idx  = res_pc[IDX_BITS+1:2];

  branch_cond u_cond (
    .funct3_i  (res_funct3),
    .eq_i      (res_eq),
    .less_i    (res_less),
    .less_u_i  (res_less_u),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  assign res_legal = res_valid && !cond_illegal;
  assign res_mis   = res_legal && (cond_taken != res_pred_taken);

  always_comb begin
    cnt_cur = cnt_q[res_idx];
    cnt_d   = cnt_cur;
    if (cond_taken && (cnt_cur != CNT_MAX)) begin
      cnt_d = cnt_cur + 1'b1;
    end else if (!cond_taken && (cnt_cur != '0)) begin
      cnt_d = cnt_cur - 1'b1;
    end
  end

  // The lookup reads cnt_q before this edge's update lands: read-before-write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) cnt_q[i] <= CNT_RST;
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      res_done_q       <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_illegal_q    <= 1'b0;
    end else begin
      pred_valid_q     <= pred_req;
      pred_taken_q     <= pred_req && cnt_q[pred_idx][CNT_BITS-1];
      res_done_q       <= res_valid;
      res_taken_q      <= res_valid && cond_taken;
      res_mispredict_q <= res_mis;
      res_illegal_q    <= res_valid && cond_illegal;
      if (res_legal) cnt_q[res_idx] <= cnt_d;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign res_done       = res_done_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign res_illegal    = res_illegal_q;

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (res_legal && (stat_br_q != '1)) stat_br_q <= stat_br_q + 32'd1;
      if (res_mis && (stat_mp_q != '1))   stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a random
// phase, with expected outputs queued at drive time and popped after each edge.
module tb_branch_predictor;

  localparam int XLEN     = 32;
  localparam int IDX_BITS = 6;
  localparam int CNT_BITS = 2;
  localparam int DEPTH    = 2 ** IDX_BITS;
  localparam int CMAX     = (1 << CNT_BITS) - 1;
  localparam int CRST     = (1 << (CNT_BITS - 1)) - 1;

  logic            clk;
  logic            rst_n;
  logic            pred_req;
  logic [XLEN-1:0] pred_pc;
  logic            pred_valid, pred_taken;
  logic            res_valid;
  logic [XLEN-1:0] res_pc;
  logic [2:0]      res_funct3;
  logic            res_eq, res_less, res_less_u, res_pred_taken;
  logic            res_done, res_taken, res_mispredict, res_illegal;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  branch_predictor #(.XLEN(XLEN), .IDX_BITS(IDX_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_funct3     (res_funct3),
    .res_eq         (res_eq),
    .res_less       (res_less),
    .res_less_u     (res_less_u),
    .res_pred_taken (res_pred_taken),
    .res_done       (res_done),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict),
    .res_illegal    (res_illegal)
`ifdef BRANCH_PRED_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_mis = 0;
  logic [1:0] exp_pred_q[$];   // {valid, taken}
  logic [3:0] exp_res_q[$];    // {done, taken, mispredict, illegal}
  int         model[DEPTH];
  int         exp_br, exp_mp;
  bit         pred_pushed, res_pushed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'(pc[IDX_BITS+1:2]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    pred_req       = 1'b0;
    pred_pc        = '0;
    res_valid      = 1'b0;
    res_pc         = '0;
    res_funct3     = 3'b000;
    res_eq         = 1'b0;
    res_less       = 1'b0;
    res_less_u     = 1'b0;
    res_pred_taken = 1'b0;
  endtask

  // Call before drive_res in the same cycle so the expectation sees the pre-update counter.
  task automatic drive_pred(input logic [XLEN-1:0] pc);
    pred_req = 1'b1;
    pred_pc  = pc;
    exp_pred_q.push_back({1'b1, ((model[idx_of(pc)] >> (CNT_BITS - 1)) & 1) == 1});
    pred_pushed = 1'b1;
  endtask

  task automatic drive_res(input logic [XLEN-1:0] pc, input logic [2:0] f3,
                           input bit eq, input bit lt, input bit ltu, input bit pt);
    bit tk, ill, mis;
    int i;
    tk  = 1'b0;
    ill = 1'b0;
    case (f3)
      3'b000:  tk = eq;
      3'b001:  tk = !eq;
      3'b100:  tk = lt;
      3'b101:  tk = !lt;
      3'b110:  tk = ltu;
      3'b111:  tk = !ltu;
      default: ill = 1'b1;
    endcase
    mis = !ill && (tk != pt);
    exp_res_q.push_back({1'b1, tk, mis, ill});
    res_pushed = 1'b1;
    if (!ill) begin
      i = idx_of(pc);
      if (tk && model[i] < CMAX) model[i]++;
      if (!tk && model[i] > 0)   model[i]--;
      exp_br++;
      if (mis) exp_mp++;
    end
    res_valid      = 1'b1;
    res_pc         = pc;
    res_funct3     = f3;
    res_eq         = eq;
    res_less       = lt;
    res_less_u     = ltu;
    res_pred_taken = pt;
  endtask

  task automatic tick(input string tag);
    if (!pred_pushed) exp_pred_q.push_back(2'b00);
    if (!res_pushed)  exp_res_q.push_back(4'b0000);
    @(posedge clk);
    #1;
    check({tag, "/pred"}, {30'd0, pred_valid, pred_taken}, {30'd0, exp_pred_q.pop_front()});
    check({tag, "/res"}, {28'd0, res_done, res_taken, res_mispredict, res_illegal},
          {28'd0, exp_res_q.pop_front()});
`ifdef BRANCH_PRED_STATS_EN
    check({tag, "/stat_br"}, stat_branches, exp_br);
    check({tag, "/stat_mp"}, stat_mispredicts, exp_mp);
`endif
    clear_inputs();
    pred_pushed = 1'b0;
    res_pushed  = 1'b0;
  endtask

  // Reset with live requests on both ports: they must leave no trace.
  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst_n = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = CRST;
      exp_br = 0;
      exp_mp = 0;
      pred_req = 1'b1; pred_pc = 32'h40;
      res_valid = 1'b1; res_pc = 32'h40; res_funct3 = 3'b000; res_eq = 1'b1;
      res_pred_taken = 1'b0;
      tick("reset");
    end
    rst_n = 1'b1;
    tick("post_reset_idle");
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    pred_pushed = 1'b0;
    res_pushed  = 1'b0;
    exp_br = 0;
    exp_mp = 0;

    do_reset(2);

    // Fresh table predicts weakly not-taken.
    drive_pred(32'h100); tick("lookup_after_reset");

    // Two taken BEQs predicted not-taken: both mispredict, counter 1->3.
    drive_res(32'h100, 3'b000, 1, 0, 0, 0); tick("beq_taken_1");
    drive_res(32'h100, 3'b000, 1, 0, 0, 0); tick("beq_taken_2");
    drive_pred(32'h100); tick("lookup_after_train");

    // Saturate high then walk down: 5 taken (BNE eq=0), 2 not-taken (BLT less=0).
    for (int k = 0; k < 5; k++) begin
      drive_res(32'h40, 3'b001, 0, 0, 0, 1); tick("sat_up");
    end
    drive_res(32'h40, 3'b100, 0, 0, 0, 1); tick("down_1");
    drive_res(32'h40, 3'b100, 0, 0, 0, 0); tick("down_2");
    check("model_cnt_0x40", model[idx_of(32'h40)], 1);
    drive_pred(32'h40); tick("lookup_cnt1");

    // Same-cycle lookup and taken update: lookup sees the old counter.
    drive_pred(32'h40);
    drive_res(32'h40, 3'b111, 0, 0, 0, 0); tick("rbw_same_cycle");
    drive_pred(32'h40); tick("rbw_next");

    // Illegal funct3 values: no table change, no mispredict, no stats.
    drive_res(32'h40, 3'b010, 1, 1, 1, 1); tick("illegal_010");
    drive_res(32'h40, 3'b011, 0, 0, 0, 1); tick("illegal_011");
    drive_pred(32'h40); tick("lookup_after_illegal");

    // 0x000 and 0x100 share an index.
    drive_res(32'h000, 3'b101, 0, 1, 0, 1); tick("alias_nt_1");
    drive_res(32'h000, 3'b101, 0, 1, 0, 1); tick("alias_nt_2");
    drive_pred(32'h100); tick("alias_lookup_100");
    drive_res(32'h100, 3'b110, 0, 0, 1, 0); tick("alias_t");
    drive_pred(32'h000); tick("alias_lookup_000");
    drive_res(32'h44, 3'b000, 1, 0, 0, 1); tick("pre_reset_res");

    // Mid-stream reset restores every counter.
    do_reset(1);
    drive_pred(32'h000); tick("post_reset_000");
    drive_pred(32'h40);  tick("post_reset_040");
    drive_pred(32'h100); tick("post_reset_100");
    drive_pred(32'h44);  tick("post_reset_044");

    // Random concurrent traffic on a small set of indices (plus full-width PCs).
    for (int k = 0; k < 60; k++) begin
      logic [XLEN-1:0] ppc, rpc;
      ppc = {$urandom} & ~32'h3;
      rpc = {$urandom} & ~32'h3;
      if ($urandom_range(0, 3) != 0) begin
        ppc = (ppc & ~32'hFC) | (32'($urandom_range(0, 3)) << 2);
        rpc = (rpc & ~32'hFC) | (32'($urandom_range(0, 3)) << 2);
      end
      if ($urandom_range(0, 1) == 1) drive_pred(ppc);
      if ($urandom_range(0, 3) != 0)
        drive_res(rpc, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      tick("random");
    end

    check("queues_drained", exp_pred_q.size() + exp_res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
